pe_array_ctrl: RTL

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_pkg.sv | 40 ++++
 rtl/pe_array_ctrl_if.sv | 34 +++
 rtl/dwell_cnt.sv | 34 +++
 rtl/pe_array_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared types for the PE array controller and the PE tile.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package pe_array_pkg;

  // Controller FSM states. DRAIN is a one-cycle gap after the last weight
  // so the final cfg beat is still presented under the LOAD_W phase.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_LOAD_X = 3'd3,
    ST_MAC    = 3'd4
  } state_t;

  // Array-wide phase as seen by the PE tiles.
  typedef enum logic [1:0] {
    GS_LOAD_W = 2'd0,
    GS_LOAD_X = 2'd1,
    GS_MAC    = 2'd2,
    GS_IDLE   = 2'd3
  } gstate_t;

  localparam int DWELL_W = 8;

  function automatic gstate_t gs_of(input state_t s);
    case (s)
      ST_LOAD_W, ST_DRAIN: return GS_LOAD_W;
      ST_LOAD_X:           return GS_LOAD_X;
      ST_MAC:              return GS_MAC;
      default:             return GS_IDLE;
    endcase
  endfunction

  // A dwell of zero cycles is meaningless; run such a phase for one cycle.
  function automatic logic [DWELL_W-1:0] min1(input logic [DWELL_W-1:0] v);
    return (v == '0) ? DWELL_W'(1) : v;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: control, weight-stream and cfg-bus signals of the PE array controller.
// Latency: n/a (wiring only).
// Backpressure: weight stream is valid/ready; cfg bus has no backpressure.
// Ports: master = sequencer/host side, slave = pe_array_ctrl.
interface pe_array_ctrl_if #(
  parameter int DW    = 8,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
);
  logic                   start;
  logic                   abort;
  logic [7:0]             x_cycles;
  logic [7:0]             mac_cycles;
  logic [DW-1:0]          w_data;
  logic                   w_valid;
  logic                   w_ready;
  logic [ROW_W+COL_W-1:0] cfg_addr;
  logic [DW-1:0]          cfg_data;
  logic                   cfg_valid;
  logic [1:0]             global_state;
  logic                   x_req;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, x_cycles, mac_cycles, w_data, w_valid,
    input  w_ready, cfg_addr, cfg_data, cfg_valid, global_state, x_req, busy, done
  );

  modport slave (
    input  start, abort, x_cycles, mac_cycles, w_data, w_valid,
    output w_ready, cfg_addr, cfg_data, cfg_valid, global_state, x_req, busy, done
  );
endinterface

// File: rtl/dwell_cnt.sv
// dwell_cnt: loadable 8-bit down counter; expire flags the last cycle of a dwell.
// Latency: load takes effect next cycle; expire is combinational from the count.
// Backpressure: none.
// Ports: clk/rst, clr (sync clear, highest priority), load/load_val, expire.
module dwell_cnt
  import pe_array_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  // Loaded with N on the cycle before a phase starts, so the phase sees
  // N, N-1, ..., 1 and expire marks its final cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences a PE array through LOAD_W -> LOAD_X -> MAC, streaming weights to PEs row-major.
// Latency: accepted weight appears on the cfg bus one cycle later; all outputs but w_ready registered.
// Backpressure: w_ready high only in LOAD_W (dropped during abort); cfg bus cannot stall.
// Ports: clk, rst (async active-high), bus (pe_array_ctrl_if.slave).
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pe_array_ctrl_if.slave  bus
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t             state, state_d;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [DWELL_W-1:0] x_cyc_q, mac_cyc_q;
  logic [DW-1:0]      w_dat;
  logic               beat, last_beat;
  logic               dw_clr, dw_load, dw_expire;
  logic [DWELL_W-1:0] dw_val;

  assign w_dat       = bus.w_data;
  assign bus.w_ready = (state == ST_LOAD_W) && !bus.abort;
  assign beat        = bus.w_valid && bus.w_ready;
  assign last_beat   = (row == LAST_ROW) && (col == LAST_COL);

  // One counter serves both timed phases: load x on DRAIN, reload with mac
  // on the final LOAD_X cycle.
  assign dw_clr  = bus.abort;
  assign dw_load = (state == ST_DRAIN) || ((state == ST_LOAD_X) && dw_expire);
  assign dw_val  = (state == ST_DRAIN) ? x_cyc_q : mac_cyc_q;

  dwell_cnt u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (dw_clr),
    .load     (dw_load),
    .load_val (dw_val),
    .expire   (dw_expire)
  );

  always_comb begin
    state_d = state;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (bus.start)          state_d = ST_LOAD_W;
        ST_LOAD_W: if (beat && last_beat)  state_d = ST_DRAIN;
        ST_DRAIN:                          state_d = ST_LOAD_X;
        ST_LOAD_X: if (dw_expire)          state_d = ST_MAC;
        ST_MAC:    if (dw_expire)          state_d = ST_IDLE;
        default:                           state_d = ST_IDLE;
      endcase
    end
  end

  // Phase outputs are registered from the next state so they line up with
  // the state register rather than lagging it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      row              <= '0;
      col              <= '0;
      x_cyc_q          <= '0;
      mac_cyc_q        <= '0;
      bus.cfg_valid    <= 1'b0;
      bus.cfg_addr     <= '0;
      bus.cfg_data     <= '0;
      bus.global_state <= GS_IDLE;
      bus.x_req        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      state            <= state_d;
      bus.global_state <= gs_of(state_d);
      bus.x_req        <= (state_d == ST_LOAD_X);
      bus.busy         <= (state_d != ST_IDLE);
      bus.cfg_valid    <= 1'b0;
      bus.done         <= 1'b0;

      if (bus.abort) begin
        row <= '0;
        col <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              x_cyc_q   <= min1(bus.x_cycles);
              mac_cyc_q <= min1(bus.mac_cycles);
              row       <= '0;
              col       <= '0;
            end
          end
          ST_LOAD_W: begin
            if (beat) begin
              bus.cfg_valid <= 1'b1;
              bus.cfg_data  <= w_dat;
              bus.cfg_addr  <= {row, col};
              if (col == LAST_COL) begin
                col <= '0;
                row <= last_beat ? '0 : row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
          ST_MAC: begin
            if (dw_expire) bus.done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
